// File: rtl/operator_modulation_router.sv
// ============================================================================
// Module   : operator_modulation_router
// Brief    : Captures operator output samples and returns the phase-modulation
//            word (self-feedback or paired-modulator output) for the next pass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operator_modulation_router #(
    parameter int OP_OUT_WIDTH = 13,
    parameter int NUM_OPS      = 18,
    parameter int OP_NUM_WIDTH = 5,
    parameter int FB_WIDTH     = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [OP_NUM_WIDTH-1:0]        wr_op_num,
    input  logic signed [OP_OUT_WIDTH-1:0] wr_data,
    input  logic                           rd_en,
    input  logic [OP_NUM_WIDTH-1:0]        rd_op_num,
    input  logic [FB_WIDTH-1:0]            fb_p0,
    input  logic                           cnt_p0,
    input  logic                           rhythm_en,
    output logic signed [OP_OUT_WIDTH-1:0] modulation_p1,
    output logic                           busy
);

    localparam int                    C_SUM_W   = OP_OUT_WIDTH + 1;
    localparam int                    C_SH_W    = 4;
    localparam logic [OP_NUM_WIDTH-1:0] C_NUM_OPS = OP_NUM_WIDTH'(NUM_OPS);
    localparam logic [OP_NUM_WIDTH-1:0] C_LAST    = OP_NUM_WIDTH'(NUM_OPS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                         r_state;
    logic [OP_NUM_WIDTH-1:0]        r_clr_cnt;
    logic                           r_busy;
    logic signed [OP_OUT_WIDTH-1:0] r_mod;
    logic signed [OP_OUT_WIDTH-1:0] r_cur  [NUM_OPS];
    logic signed [OP_OUT_WIDTH-1:0] r_prev [NUM_OPS];

    logic                           w_wr_hit;
    logic                           w_rd_valid;
    logic [OP_NUM_WIDTH-1:0]        w_rd_idx;
    logic [OP_NUM_WIDTH-1:0]        w_sub;
    logic [OP_NUM_WIDTH-1:0]        w_ch;
    logic                           w_carrier;
    logic [OP_NUM_WIDTH-1:0]        w_mod_idx;
    logic signed [OP_OUT_WIDTH-1:0] w_self_cur;
    logic signed [OP_OUT_WIDTH-1:0] w_self_prev;
    logic signed [OP_OUT_WIDTH-1:0] w_pair_cur;
    logic signed [C_SUM_W-1:0]      w_sum;
    logic signed [C_SUM_W-1:0]      w_shifted;
    logic [C_SH_W-1:0]              w_shamt;
    logic signed [OP_OUT_WIDTH-1:0] w_mod_next;

    // Slot decode: six slots per group, first three modulators, last three carriers.
    assign w_wr_hit   = (r_state == ST_RUN) && wr_en && (wr_op_num < C_NUM_OPS);
    assign w_rd_valid = (rd_op_num < C_NUM_OPS);
    assign w_rd_idx   = w_rd_valid ? rd_op_num : '0;
    assign w_sub      = w_rd_idx % OP_NUM_WIDTH'(6);
    assign w_ch       = (w_rd_idx / OP_NUM_WIDTH'(6)) * OP_NUM_WIDTH'(3)
                      + (w_sub % OP_NUM_WIDTH'(3));
    assign w_carrier  = (w_sub >= OP_NUM_WIDTH'(3));
    assign w_mod_idx  = w_carrier ? (w_rd_idx - OP_NUM_WIDTH'(3)) : '0;

    // Write-first forwarding so a same-cycle read sees the post-write history.
    assign w_self_cur  = (w_wr_hit && (wr_op_num == w_rd_idx)) ? wr_data : r_cur[w_rd_idx];
    assign w_self_prev = (w_wr_hit && (wr_op_num == w_rd_idx)) ? r_cur[w_rd_idx] : r_prev[w_rd_idx];
    assign w_pair_cur  = (w_wr_hit && (wr_op_num == w_mod_idx)) ? wr_data : r_cur[w_mod_idx];

    // Sum is widened by one bit so two full-scale samples cannot wrap before the shift.
    assign w_sum     = C_SUM_W'(w_self_cur) + C_SUM_W'(w_self_prev);
    assign w_shamt   = C_SH_W'(9) - C_SH_W'(fb_p0);
    assign w_shifted = w_sum >>> w_shamt;

    always_comb begin
        w_mod_next = '0;
        if (!w_rd_valid) begin
            w_mod_next = '0;
        end else if (rhythm_en && ((w_ch == OP_NUM_WIDTH'(7)) || (w_ch == OP_NUM_WIDTH'(8)))) begin
            w_mod_next = '0;
        end else if (!w_carrier) begin
            if (fb_p0 != '0) begin
                w_mod_next = w_shifted[OP_OUT_WIDTH-1:0];
            end
        end else if (!cnt_p0) begin
            w_mod_next = w_pair_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
            r_mod     <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cur[r_clr_cnt]  <= '0;
                    r_prev[r_clr_cnt] <= '0;
                    r_clr_cnt         <= r_clr_cnt + 1'b1;
                    if (rd_en) begin
                        r_mod <= '0;
                    end
                    if (r_clr_cnt == C_LAST) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_busy <= 1'b0;
                    if (w_wr_hit) begin
                        r_prev[wr_op_num] <= r_cur[wr_op_num];
                        r_cur[wr_op_num]  <= wr_data;
                    end
                    if (rd_en) begin
                        r_mod <= w_mod_next;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign modulation_p1 = r_mod;
    assign busy          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_operator_modulation_router.sv
// ============================================================================
// Module   : tb_operator_modulation_router
// Brief    : Self-checking bench with a behavioural slot-history model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operator_modulation_router;

    logic               clk = 1'b0;
    logic               reset;
    logic               wr_en;
    logic [4:0]         wr_op_num;
    logic signed [12:0] wr_data;
    logic               rd_en;
    logic [4:0]         rd_op_num;
    logic [2:0]         fb_p0;
    logic               cnt_p0;
    logic               rhythm_en;
    logic signed [12:0] modulation_p1;
    logic               busy;

    int                 n_checks = 0;
    int                 n_pass   = 0;
    int                 m_cur  [18];
    int                 m_prev [18];
    logic signed [12:0] exp_mod;

    operator_modulation_router dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_op_num     (wr_op_num),
        .wr_data       (wr_data),
        .rd_en         (rd_en),
        .rd_op_num     (rd_op_num),
        .fb_p0         (fb_p0),
        .cnt_p0        (cnt_p0),
        .rhythm_en     (rhythm_en),
        .modulation_p1 (modulation_p1),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic signed [12:0] ref_mod(input int n, input int fb, input bit cn, input bit rh);
        int pos;
        int ch;
        if (n >= 18) return 13'sd0;
        pos = n % 6;
        ch  = (n / 6) * 3 + pos % 3;
        if (rh && (ch == 7 || ch == 8)) return 13'sd0;
        if (pos < 3) begin
            if (fb == 0) return 13'sd0;
            return 13'((m_cur[n] + m_prev[n]) >>> (9 - fb));
        end
        if (cn) return 13'sd0;
        return 13'(m_cur[n - 3]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 18; i++) begin
            m_cur[i]  = 0;
            m_prev[i] = 0;
        end
        exp_mod = 13'sd0;
    endtask

    // One RUN-state cycle: drive at negedge, update model write-first, settle after posedge.
    task automatic step(input bit we, input int wn, input int wd, input bit re, input int rn,
                        input int fb, input bit cn, input bit rh);
        @(negedge clk);
        wr_en = we; wr_op_num = 5'(wn); wr_data = 13'(wd);
        rd_en = re; rd_op_num = 5'(rn); fb_p0 = 3'(fb); cnt_p0 = cn; rhythm_en = rh;
        if (we && wn < 18) begin
            m_prev[wn] = m_cur[wn];
            m_cur[wn]  = wd;
        end
        if (re) exp_mod = ref_mod(rn, fb, cn, rh);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_op_num = '0; wr_data = '0; rd_op_num = '0; fb_p0 = '0; cnt_p0 = 1'b0; rhythm_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || modulation_p1 !== 13'sd0)
            $display("FAIL reset_state busy=%b mod=%0d required busy=1 mod=0", busy, modulation_p1);
        else n_pass++;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        rd_en = 1'b1; rd_op_num = 5'd0; fb_p0 = 3'd7;
        wr_en = 1'b1; wr_op_num = 5'd0; wr_data = 13'sd100;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (busy !== (k < 18))
                $display("FAIL clear_busy cycle=%0d busy=%b required=%b", k, busy, (k < 18));
            else n_pass++;
            n_checks++;
            if (modulation_p1 !== 13'sd0)
                $display("FAIL clear_read cycle=%0d mod=%0d required=0", k, modulation_p1);
            else n_pass++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        step(0, 0, 0, 1, 0, 7, 0, 0);
        n_checks++;
        if (modulation_p1 !== exp_mod)
            $display("FAIL clear_write_ignored mod=%0d required=%0d", modulation_p1, exp_mod);
        else n_pass++;
    endtask

    task automatic test_feedback();
        int fbs[3] = '{7, 1, 0};
        step(1, 0, 100, 0, 0, 0, 0, 0);
        step(1, 0, 200, 0, 0, 0, 0, 0);
        foreach (fbs[i]) begin
            step(0, 0, 0, 1, 0, fbs[i], 0, 0);
            n_checks++;
            if (modulation_p1 !== exp_mod)
                $display("FAIL feedback fb=%0d mod=%0d required=%0d", fbs[i], modulation_p1, exp_mod);
            else n_pass++;
        end
        step(1, 1, -4096, 0, 0, 0, 0, 0);
        step(1, 1, -4096, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 7, 0, 0);
        n_checks++;
        if (modulation_p1 !== -13'sd2048)
            $display("FAIL feedback_negative mod=%0d required=-2048", modulation_p1);
        else n_pass++;
    endtask

    task automatic test_carrier();
        step(1, 0, 'h123, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0, 0, 0);
        n_checks++;
        if (modulation_p1 !== exp_mod)
            $display("FAIL carrier_fm mod=%0d required=%0d", modulation_p1, exp_mod);
        else n_pass++;
        step(0, 0, 0, 1, 3, 0, 1, 0);
        n_checks++;
        if (modulation_p1 !== exp_mod)
            $display("FAIL carrier_add mod=%0d required=%0d", modulation_p1, exp_mod);
        else n_pass++;
        step(1, 0, 'h55, 1, 3, 0, 0, 0);
        n_checks++;
        if (modulation_p1 !== 13'sh55)
            $display("FAIL carrier_forward mod=%0d required=%0d", modulation_p1, 13'sh55);
        else n_pass++;
        step(1, 2, 1000, 1, 2, 6, 0, 0);
        n_checks++;
        if (modulation_p1 !== exp_mod)
            $display("FAIL self_forward mod=%0d required=%0d", modulation_p1, exp_mod);
        else n_pass++;
    endtask

    task automatic test_rhythm();
        step(1, 13, 500, 0, 0, 0, 0, 0);
        step(1, 13, 500, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 13, 7, 0, 1);
        n_checks++;
        if (modulation_p1 !== 13'sd0)
            $display("FAIL rhythm_on mod=%0d required=0", modulation_p1);
        else n_pass++;
        step(0, 0, 0, 1, 13, 7, 0, 0);
        n_checks++;
        if (modulation_p1 !== 13'sd250)
            $display("FAIL rhythm_off mod=%0d required=250", modulation_p1);
        else n_pass++;
        step(1, 12, 40, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 15, 0, 0, 1);
        n_checks++;
        if (modulation_p1 !== 13'sd40)
            $display("FAIL bass_drum mod=%0d required=40", modulation_p1);
        else n_pass++;
        step(1, 14, 77, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 17, 0, 0, 1);
        n_checks++;
        if (modulation_p1 !== 13'sd0)
            $display("FAIL rhythm_carrier mod=%0d required=0", modulation_p1);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 19)), int'($urandom_range(0, 8191)) - 4096,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 19)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (modulation_p1 !== exp_mod)
                $display("FAIL random iter=%0d mod=%0d required=%0d", i, modulation_p1, exp_mod);
            else n_pass++;
        end
    endtask

    task automatic test_oob();
        step(1, 20, 999, 1, 20, 7, 0, 0);
        n_checks++;
        if (modulation_p1 !== 13'sd0)
            $display("FAIL oob_read mod=%0d required=0", modulation_p1);
        else n_pass++;
        for (int n = 0; n < 18; n++) begin
            step(0, 0, 0, 1, n, 5, 0, 0);
            n_checks++;
            if (modulation_p1 !== exp_mod)
                $display("FAIL oob_no_change slot=%0d mod=%0d required=%0d", n, modulation_p1, exp_mod);
            else n_pass++;
        end
    endtask

    task automatic test_midreset();
        for (int n = 0; n < 18; n++) step(1, n, n * 37 + 11, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1; rd_en = 1'b1; rd_op_num = 5'd0; fb_p0 = 3'd7; wr_en = 1'b1; wr_data = 13'sd5;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || modulation_p1 !== 13'sd0)
            $display("FAIL midreset_state busy=%b mod=%0d required busy=1 mod=0", busy, modulation_p1);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (17) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1)
            $display("FAIL midclear_restart busy=%b required=1", busy);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL midclear_done busy=%b required=0", busy);
        else n_pass++;
        for (int n = 0; n < 18; n++) begin
            for (int fb = 0; fb < 8; fb++) begin
                for (int cn = 0; cn < 2; cn++) begin
                    step(0, 0, 0, 1, n, fb, 1'(cn), 1'(fb & 1));
                    n_checks++;
                    if (modulation_p1 !== 13'sd0)
                        $display("FAIL post_reset_zero slot=%0d fb=%0d cnt=%0d mod=%0d required=0",
                                 n, fb, cn, modulation_p1);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_feedback();
        test_carrier();
        test_rhythm();
        test_random();
        test_oob();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/operator_modulation_router.md
Name: operator_modulation_router

Overview:
- Consumer end of the operator output stream from the phase generator.
- Captures each operator's signed output sample and keeps the last two samples per operator slot.
- Returns the phase-modulation word the phase generator adds to the phase of the next operator it processes. A modulator gets its self-feedback term; a carrier gets its paired modulator's current output, or zero.
- Sits between the operator pipeline output and the modulation input of the next operator pass.

Parameters:
- OP_OUT_WIDTH, 13, signed operator output width; also the width of the modulation output.
- NUM_OPS, 18, number of operator slots in the bank.
- OP_NUM_WIDTH, 5, operator index width.
- FB_WIDTH, 3, channel feedback field width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  capture strobe for an operator output.
- wr_op_num  in  OP_NUM_WIDTH  slot being written.
- wr_data  in  OP_OUT_WIDTH  signed operator output (out_p6 of the phase generator).
- rd_en  in  1  modulation request (p0).
- rd_op_num  in  OP_NUM_WIDTH  slot about to be processed (p0).
- fb_p0  in  FB_WIDTH  feedback setting of the slot's channel.
- cnt_p0  in  1  channel connection: 0 = FM, 1 = additive.
- rhythm_en  in  1  rhythm mode enable.
- modulation_p1  out  OP_OUT_WIDTH  modulation word, valid 1 cycle after rd_en.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Slot decode: ch = (n/6)*3 + (n%6)%3; carrier if (n%6) >= 3, else modulator. A carrier's paired modulator is slot n-3.
- Storage: cur[NUM_OPS] and prev[NUM_OPS], each OP_OUT_WIDTH signed. Registers or RAM are both acceptable.
- FSM states: CLEAR, RUN.
  - reset (any cycle, including mid-clear or mid-request) → CLEAR. The clear counter is set to 0, busy=1, modulation_p1=0.
  - CLEAR: each cycle, cur[cnt] and prev[cnt] are set to 0 and the counter increments. After slot NUM_OPS-1 is cleared → RUN. Total NUM_OPS cycles.
  - In CLEAR, wr_en is ignored and rd_en gives modulation_p1=0.
  - RUN: busy=0.
- Write, in RUN with wr_en=1: prev[wr_op_num] <= cur[wr_op_num]; cur[wr_op_num] <= wr_data.
  - wr_op_num >= NUM_OPS: the write is ignored.
- Read, in RUN with rd_en=1. modulation_p1 is registered 1 cycle later and takes the first matching rule below:
  - rd_op_num >= NUM_OPS → 0.
  - rhythm_en=1 and ch ∈ {7,8} → 0 for both slots. No feedback is applied.
  - Modulator with fb_p0=0 → 0.
  - Modulator with fb_p0≠0 → (cur[n] + prev[n]) >>> (9 - fb_p0).
    - Sum is sign-extended to OP_OUT_WIDTH+1 bits; the shift is arithmetic.
    - The result is truncated to OP_OUT_WIDTH (two's complement wrap).
  - Carrier with cnt_p0=1 → 0.
  - Carrier with cnt_p0=0 → cur[n-3].
  - Channel 6 (bass drum) follows the normal rules regardless of rhythm_en.
- Write/read collision in the same cycle: write-first forwarding.
  - A read in that cycle sees the post-write cur and prev of the written slot.
  - This covers a carrier reading its modulator in the cycle the modulator is written, and a modulator reading its own slot.
- When rd_en=0, modulation_p1 holds its last value.
- fb_p0, cnt_p0 and rhythm_en are sampled only with rd_en.
- Outputs at reset: modulation_p1=0, busy=1.

Test Plan:
- Reset release → busy=1 for exactly 18 cycles, then 0. rd_en on slot 0 during clear → modulation_p1=0. wr_en during clear → no effect: after clear, slot 0 fb=7 read → 0.
- Write slot 0 with 100, then 200. Read slot 0 with fb=7 → (300)>>>2 = 75. fb=1 → 300>>>8 = 1. fb=0 → 0.
- Write slot 1 with -4096, then -4096. Read with fb=7 → -2048 (sum -8192 must not wrap before the shift).
- Write slot 0 = 0x0123. Read slot 3 with cnt=0 → 0x0123; with cnt=1 → 0. Same-cycle wr slot 0 = 0x0055 with rd slot 3 → 0x0055 (forwarding).
- Write slot 13 (ch 7 modulator) = 500 twice. rhythm_en=1 with fb=7 → 0; rhythm_en=0 → 250. Write slot 12 (ch 6 modulator) = 40; read slot 15 (ch 6 carrier) with rhythm_en=1, cnt=0 → 40.
- Assert reset mid-sequence with nonzero stored data → busy=1; after 18 cycles every slot reads 0 under every fb/cnt setting. Read/write of op_num 20 → 0 and no state change.
